// File: rtl/text_console_pkg.sv
// rtl/text_console_pkg.sv - shared states and control-code constants for the text console controller
package text_console_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCR_RD  = 3'd1,
        SCR_WR  = 3'd2,
        CLR_ROW = 3'd3,
        CLR_ALL = 3'd4
    } state_t;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] CHAR_DEL   = 8'h7F;

endpackage

// File: rtl/text_console_cursor.sv
// rtl/text_console_cursor.sv - cursor column/row plus incrementally maintained linear VRAM address
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset (cursor homes)
//   cmd_advance        move one column right, wrapping to the next row
//   cmd_newline        column 0, next row (row held on the last row)
//   cmd_cr             column 0, same row
//   cmd_bs             one column left unless already at column 0
//   cmd_home           cursor to (0,0)
//   col, row, addr     current cursor position and its row*COLS+col address
//   wrap               the command presented this cycle moves to a new row
//   scroll_needed      cursor is on the last row, so a wrap must scroll
module text_console_cursor #(
    parameter int COLS       = 80,
    parameter int ROWS       = 60,
    parameter int ADDR_WIDTH = 13,
    parameter int COL_W      = $clog2(COLS),
    parameter int ROW_W      = $clog2(ROWS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_advance,
    input  logic                  cmd_newline,
    input  logic                  cmd_cr,
    input  logic                  cmd_bs,
    input  logic                  cmd_home,
    output logic [COL_W-1:0]      col,
    output logic [ROW_W-1:0]      row,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wrap,
    output logic                  scroll_needed
);

    localparam logic [COL_W-1:0]      LAST_COL   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]      LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] COLS_A     = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] LAST_COL_A = ADDR_WIDTH'(COLS - 1);

    logic                  at_last_col;
    logic                  at_last_row;
    logic [ADDR_WIDTH-1:0] col_a;

    assign at_last_col   = (col == LAST_COL);
    assign at_last_row   = (row == LAST_ROW);
    assign col_a         = ADDR_WIDTH'(col);
    assign wrap          = (cmd_advance && at_last_col) || cmd_newline;
    assign scroll_needed = at_last_row;

    // The address tracks the cursor by add/subtract only; the row start is
    // recovered as addr-col, so no multiplier is ever needed.
    always_ff @(posedge clk) begin
        if (!rst_n || cmd_home) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (cmd_advance) begin
            if (at_last_col) begin
                col <= '0;
                if (at_last_row) begin
                    // Scroll will move this row up; cursor lands at its start.
                    addr <= addr - LAST_COL_A;
                end else begin
                    row  <= row + 1'b1;
                    addr <= addr + 1'b1;
                end
            end else begin
                col  <= col + 1'b1;
                addr <= addr + 1'b1;
            end
        end else if (cmd_newline) begin
            col <= '0;
            if (at_last_row) begin
                addr <= addr - col_a;
            end else begin
                row  <= row + 1'b1;
                addr <= addr - col_a + COLS_A;
            end
        end else if (cmd_cr) begin
            col  <= '0;
            addr <= addr - col_a;
        end else if (cmd_bs && (col != '0)) begin
            col  <= col - 1'b1;
            addr <= addr - 1'b1;
        end
    end

endmodule

// File: rtl/text_console_ctrl.sv
// rtl/text_console_ctrl.sv - byte-stream text console: glyph writes, clear and scroll on the VRAM CPU port
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   char_valid/char_data/char_ready byte stream in; transfer on valid && ready
//   vram_we/vram_addr/vram_wdata   registered VRAM CPU port
//   vram_rdata                     VRAM read data for the address currently on vram_addr
//   cursor_col, cursor_row         cursor position
//   busy                           clear or scroll sequence running
module text_console_ctrl #(
    parameter int COLS       = 80,
    parameter int ROWS       = 60,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      char_valid,
    input  logic [7:0]                char_data,
    output logic                      char_ready,
    output logic                      vram_we,
    output logic [ADDR_WIDTH-1:0]     vram_addr,
    output logic [7:0]                vram_wdata,
    input  logic [7:0]                vram_rdata,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic [$clog2(ROWS)-1:0]   cursor_row,
    output logic                      busy
);

    import text_console_pkg::*;

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int TOTAL = COLS * ROWS;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR     = ADDR_WIDTH'(TOTAL - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_SRC     = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW_BASE = ADDR_WIDTH'(TOTAL - COLS);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    logic                  we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [7:0]            wdata_d;

    logic                  accept;
    logic                  is_print;
    logic                  cmd_advance, cmd_newline, cmd_cr, cmd_bs, cmd_home;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cur_wrap, cur_scroll_needed;
    logic                  start_scroll;

    assign char_ready   = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign accept       = char_valid && char_ready;
    assign is_print     = (char_data >= CHAR_SPACE) && (char_data != CHAR_DEL);
    assign start_scroll = cur_wrap && cur_scroll_needed;

    text_console_cursor #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .COL_W      (COL_W),
        .ROW_W      (ROW_W)
    ) u_cursor (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_advance   (cmd_advance),
        .cmd_newline   (cmd_newline),
        .cmd_cr        (cmd_cr),
        .cmd_bs        (cmd_bs),
        .cmd_home      (cmd_home),
        .col           (cursor_col),
        .row           (cursor_row),
        .addr          (cur_addr),
        .wrap          (cur_wrap),
        .scroll_needed (cur_scroll_needed)
    );

    // State, sequence counter and the registered VRAM port. Reset parks the
    // FSM in CLR_ALL so the screen is always blanked after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CLR_ALL;
            cnt_q      <= '0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= CHAR_SPACE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vram_we    <= we_d;
            vram_addr  <= addr_d;
            vram_wdata <= wdata_d;
        end
    end

    // cnt_q is the scroll source address in SCR_RD/SCR_WR and the write
    // address in CLR_ROW/CLR_ALL.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (char_data == CHAR_FF) begin
                        state_d = CLR_ALL;
                        cnt_d   = '0;
                    end else if (start_scroll) begin
                        state_d = SCR_RD;
                        cnt_d   = FIRST_SRC;
                    end
                end
            end
            SCR_RD: state_d = SCR_WR;
            SCR_WR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = CLR_ROW;
                    cnt_d   = LAST_ROW_BASE;
                end else begin
                    state_d = SCR_RD;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            CLR_ROW, CLR_ALL: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = CLR_ALL;
                cnt_d   = '0;
            end
        endcase
    end

    // Port values computed here appear on the VRAM port next cycle. The read
    // address issued in SCR_RD is on the port during SCR_WR, whose
    // vram_rdata is then copied COLS addresses lower.
    always_comb begin
        we_d        = 1'b0;
        addr_d      = vram_addr;
        wdata_d     = vram_wdata;
        cmd_advance = 1'b0;
        cmd_newline = 1'b0;
        cmd_cr      = 1'b0;
        cmd_bs      = 1'b0;
        cmd_home    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_print) begin
                        we_d        = 1'b1;
                        addr_d      = cur_addr;
                        wdata_d     = char_data;
                        cmd_advance = 1'b1;
                    end else if (char_data == CHAR_LF) begin
                        cmd_newline = 1'b1;
                    end else if (char_data == CHAR_CR) begin
                        cmd_cr = 1'b1;
                    end else if (char_data == CHAR_BS) begin
                        cmd_bs = 1'b1;
                    end else if (char_data == CHAR_FF) begin
                        cmd_home = 1'b1;
                    end
                end
            end
            SCR_RD: addr_d = cnt_q;
            SCR_WR: begin
                we_d    = 1'b1;
                addr_d  = cnt_q - FIRST_SRC;
                wdata_d = vram_rdata;
            end
            CLR_ROW, CLR_ALL: begin
                we_d    = 1'b1;
                addr_d  = cnt_q;
                wdata_d = CHAR_SPACE;
            end
            default: ;
        endcase
    end

endmodule
